// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the registered bus arbiter.
// Width helpers keep single-client and unlimited-tenure builds at one bit minimum.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

    function automatic int id_width(input int clients);
        return (clients > 1) ? $clog2(clients) : 1;
    endfunction

    function automatic int cnt_width(input int max_tenure);
        return (max_tenure > 0) ? $clog2(max_tenure + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational winner pick: rotating scan after last, or highest index when rr_mode is low.
// Zero latency; found is low when no client requests.
module bus_arb_rr_pick
    import bus_arb_pkg::*;
#(
    parameter int CLIENTS = 4,
    parameter int IDW     = id_width(CLIENTS)
) (
    input  logic [CLIENTS-1:0] req,
    input  logic [IDW-1:0]     last,
    input  logic               rr_mode,
    output logic [IDW-1:0]     winner,
    output logic               found
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        if (rr_mode) begin
            // First hit scanning last+1, last+2, ... with wrap
            for (int off = 1; off <= CLIENTS; off++) begin
                idx = IDW'((int'(last) + off) % CLIENTS);
                if (!found && req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                if (req[i]) begin
                    winner = IDW'(i);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Registered one-hot bus arbiter with tenure limit and a one-cycle turnaround between owners.
// Request-to-grant latency 1 cycle; owners hold get_bus, tenure limit forces release.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int CLIENTS     = 4,
    parameter int MAX_TENURE  = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CLIENTS-1:0]             get_bus,
    output logic [CLIENTS-1:0]             bus_granted,
    output logic [id_width(CLIENTS)-1:0]   grant_id,
    output logic                           bus_busy,
    output logic                           tenure_expired
);

    localparam int             IDW      = id_width(CLIENTS);
    localparam int             CW       = cnt_width(MAX_TENURE);
    localparam logic [IDW-1:0] LAST_RST = IDW'(CLIENTS - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_TENURE);

    arb_state_t         state, state_nxt;
    logic [CW-1:0]      tenure_cnt, cnt_nxt;
    logic [IDW-1:0]     last, last_nxt;
    logic [CLIENTS-1:0] gnt_nxt;
    logic [IDW-1:0]     id_nxt;
    logic               busy_nxt;
    logic               exp_nxt;
    logic [IDW-1:0]     pick_id;
    logic               pick_vld;

    bus_arb_rr_pick #(
        .CLIENTS (CLIENTS),
        .IDW     (IDW)
    ) u_pick (
        .req     (get_bus),
        .last    (last),
        .rr_mode (ROUND_ROBIN != 0),
        .winner  (pick_id),
        .found   (pick_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            tenure_cnt     <= '0;
            last           <= LAST_RST;
            bus_granted    <= '0;
            grant_id       <= '0;
            bus_busy       <= 1'b0;
            tenure_expired <= 1'b0;
        end else begin
            state          <= state_nxt;
            tenure_cnt     <= cnt_nxt;
            last           <= last_nxt;
            bus_granted    <= gnt_nxt;
            grant_id       <= id_nxt;
            bus_busy       <= busy_nxt;
            tenure_expired <= exp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = tenure_cnt;
        last_nxt  = last;
        gnt_nxt   = bus_granted;
        id_nxt    = grant_id;
        busy_nxt  = bus_busy;
        exp_nxt   = 1'b0;
        case (state)
            GRANT: begin
                if (!get_bus[grant_id]) begin
                    // A drop on the limit cycle counts as voluntary: no pulse
                    state_nxt = TURN;
                end else if (MAX_TENURE != 0 && tenure_cnt == CNT_MAX) begin
                    state_nxt = TURN;
                    exp_nxt   = 1'b1;
                end else if (tenure_cnt != '1) begin
                    cnt_nxt = tenure_cnt + CW'(1);
                end
                if (state_nxt == TURN) begin
                    cnt_nxt  = '0;
                    gnt_nxt  = '0;
                    id_nxt   = '0;
                    busy_nxt = 1'b0;
                end
            end
            default: begin
                if (pick_vld) begin
                    state_nxt        = GRANT;
                    cnt_nxt          = CW'(1);
                    gnt_nxt          = '0;
                    gnt_nxt[pick_id] = 1'b1;
                    id_nxt           = pick_id;
                    busy_nxt         = 1'b1;
                    if (ROUND_ROBIN != 0) begin
                        last_nxt = pick_id;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    gnt_nxt   = '0;
                    id_nxt    = '0;
                    busy_nxt  = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench: three arbiter builds (RR limit 4, fixed limit 4, RR unlimited) vs an owner-level model.
module tb_bus_arbiter_rr;

    localparam int N     = 4;
    localparam int BOUND = N * (4 + 1);

    typedef struct {
        int owner;
        int last;
        int tenure;
    } mdl_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       texp;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req  [3];
    logic [3:0] gnt  [3];
    logic [1:0] gid  [3];
    logic       busy [3];
    logic       texp [3];

    int   cfg_max [3] = '{4, 4, 0};
    bit   cfg_rr  [3] = '{1'b1, 1'b0, 1'b1};
    mdl_t m [3];
    exp_t sb [3][$];

    int checks   = 0;
    int failures = 0;
    int pulses [3];
    int order [$];
    int wait_c [4];
    int max_wait = 0;
    logic [3:0] prev_gnt0 = '0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.CLIENTS(4), .MAX_TENURE(4), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(reset), .get_bus(req[0]), .bus_granted(gnt[0]),
        .grant_id(gid[0]), .bus_busy(busy[0]), .tenure_expired(texp[0]));

    bus_arbiter_rr #(.CLIENTS(4), .MAX_TENURE(4), .ROUND_ROBIN(0)) u_fx (
        .clk(clk), .reset(reset), .get_bus(req[1]), .bus_granted(gnt[1]),
        .grant_id(gid[1]), .bus_busy(busy[1]), .tenure_expired(texp[1]));

    bus_arbiter_rr #(.CLIENTS(4), .MAX_TENURE(0), .ROUND_ROBIN(1)) u_nl (
        .clk(clk), .reset(reset), .get_bus(req[2]), .bus_granted(gnt[2]),
        .grant_id(gid[2]), .bus_busy(busy[2]), .tenure_expired(texp[2]));

    function automatic exp_t mdl_out(input mdl_t s, input logic ex);
        exp_t e;
        e.gnt  = (s.owner >= 0) ? 4'(1 << s.owner) : 4'b0;
        e.id   = (s.owner >= 0) ? 2'(s.owner) : 2'd0;
        e.busy = (s.owner >= 0);
        e.texp = ex;
        return e;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.owner  = -1;
        s.last   = N - 1;
        s.tenure = 0;
        return s;
    endfunction

    // Owner-level model: -1 means nobody holds the bus (idle or turnaround)
    task automatic mdl_step(input int d, input logic [3:0] r);
        logic ex;
        int   w;
        int   idx;
        ex = 1'b0;
        w  = -1;
        if (m[d].owner >= 0) begin
            if (!r[m[d].owner]) begin
                m[d].owner = -1;
            end else if (cfg_max[d] != 0 && m[d].tenure >= cfg_max[d]) begin
                m[d].owner = -1;
                ex = 1'b1;
            end else begin
                m[d].tenure++;
            end
        end else begin
            if (cfg_rr[d]) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m[d].last + k) % N;
                    if (w < 0 && r[idx]) w = idx;
                end
            end else begin
                for (int i = 0; i < N; i++) if (r[i]) w = i;
            end
            if (w >= 0) begin
                m[d].owner  = w;
                m[d].tenure = 1;
                if (cfg_rr[d]) m[d].last = w;
            end
        end
        sb[d].push_back(mdl_out(m[d], ex));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) for (int d = 0; d < 3; d++) mdl_step(d, req[d]);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("async_reset_dut%0d", d),
                {26'd0, gnt[d], gid[d], busy[d], texp[d]}, 32'd0);
        for (int d = 0; d < 3; d++) req[d] = '0;
        repeat (2) tick();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m[d] = mdl_reset();
            sb[d].push_back(mdl_out(m[d], 1'b0));
        end
    endtask

    // Monitor: scoreboard compare, invariants, order capture and RR wait tracking
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            for (int d = 0; d < 3; d++) sb[d].delete();
            for (int i = 0; i < N; i++) wait_c[i] = 0;
            prev_gnt0 = '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (sb[d].size() != 0) begin
                    e = sb[d].pop_front();
                    checks++;
                    if ({gnt[d], gid[d], busy[d], texp[d]} !== {e.gnt, e.id, e.busy, e.texp}) begin
                        failures++;
                        $display("FAIL sb_dut%0d t=%0t got gnt=%b id=%0d busy=%b exp=%b want gnt=%b id=%0d busy=%b exp=%b",
                                 d, $time, gnt[d], gid[d], busy[d], texp[d], e.gnt, e.id, e.busy, e.texp);
                    end
                end
                checks++;
                if ($countones(gnt[d]) > 1 || busy[d] !== (gnt[d] != 0) ||
                    (busy[d] && gnt[d] !== 4'(1 << gid[d]))) begin
                    failures++;
                    $display("FAIL onehot_dut%0d t=%0t got gnt=%b id=%0d busy=%b want one-hot matching id",
                             d, $time, gnt[d], gid[d], busy[d]);
                end
                if (texp[d]) pulses[d]++;
            end
            if (gnt[0] != 0 && prev_gnt0 == 0) order.push_back(int'(gid[0]));
            prev_gnt0 = gnt[0];
            for (int i = 0; i < N; i++) begin
                if (req[0][i] && !gnt[0][i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
        end
    end

    initial begin
        int base_o;
        int base_p;
        for (int d = 0; d < 3; d++) begin
            req[d]    = '0;
            pulses[d] = 0;
            m[d]      = mdl_reset();
        end
        #2;
        do_reset();

        // Single request, then reset asserted mid-tenure
        req[0] = 4'b0001;
        repeat (3) tick();
        chk("c0_granted", {28'd0, gnt[0]}, 32'h1);
        do_reset();

        // RR with all four holding: 0,1,2,3,0 with a pulse per forced release
        base_o = order.size();
        base_p = pulses[0];
        req[0] = 4'hF;
        repeat (26) tick();
        req[0] = '0;
        repeat (3) tick();
        chk("rr_order_len", order.size() - base_o >= 5, 1);
        if (order.size() - base_o >= 5) begin
            for (int k = 0; k < 5; k++)
                chk($sformatf("rr_order_%0d", k), order[base_o + k], k % N);
        end
        chk("rr_pulses", pulses[0] - base_p, 5);

        // Fixed priority: 2 wins over 1, then 1 after release and a turnaround
        req[1] = 4'b0110;
        repeat (4) tick();
        req[1] = 4'b0010;
        repeat (4) tick();
        chk("fx_c1_after_c2", {28'd0, gnt[1]}, 32'h2);
        req[1] = '0;
        repeat (2) tick();

        // Unlimited tenure: one owner for 100 cycles, never expires
        base_p = pulses[2];
        req[2] = 4'b0001;
        repeat (100) tick();
        chk("nl_still_granted", {28'd0, gnt[2]}, 32'h1);
        req[2] = '0;
        repeat (2) tick();
        chk("nl_no_pulse", pulses[2] - base_p, 0);

        // Owner drops exactly on the limit cycle: voluntary, no pulse
        base_p = pulses[0];
        req[0] = 4'b0001;
        repeat (4) tick();
        req[0] = '0;
        repeat (3) tick();
        chk("drop_at_limit_pulse", pulses[0] - base_p, 0);
        chk("drop_at_limit_idle", {28'd0, gnt[0]}, 32'h0);

        // Random held requests: raise at random, drop only while owning
        max_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[d][i]) begin
                        if ($urandom_range(0, 3) == 0) req[d][i] = 1'b1;
                    end else if (gnt[d][i] && $urandom_range(0, 3) == 0) begin
                        req[d][i] = 1'b0;
                    end
                end
            end
            tick();
        end
        for (int d = 0; d < 3; d++) req[d] = '0;
        repeat (4) tick();
        checks++;
        if (max_wait > BOUND) begin
            failures++;
            $display("FAIL rr_fairness got max_wait=%0d want <= %0d", max_wait, BOUND);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
